// File: rtl/env_adsr.sv
// ADSR envelope generator: five-state level machine stepped by a prescaled tick,
// applied to the oscillator sample through a registered signed x unsigned multiply.
module env_adsr #(
    parameter int PRESCALE = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate,
    input  logic [15:0] sin,
    input  logic [15:0] attack_inc,
    input  logic [15:0] decay_dec,
    input  logic [15:0] sustain_lvl,
    input  logic [15:0] release_dec,
    output logic [15:0] sample_out,
    output logic [15:0] env_level,
    output logic [2:0]  env_state,
    output logic        active
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

    state_t             state_q, state_d;
    logic [15:0]        level_q, level_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               gate_q, gate_d;
    logic [15:0]        sample_q, sample_d;

    logic               tick;
    logic               rise;
    logic               fall;
    logic [16:0]        sum17;
    logic [16:0]        dec17;
    logic [16:0]        rel17;
    logic signed [32:0] product;

    always_comb begin
        tick    = (cnt_q == CNT_MAX);
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        gate_d  = gate;
        rise    = gate & ~gate_q;
        fall    = ~gate & ((state_q == S_ATTACK) || (state_q == S_DECAY) ||
                           (state_q == S_SUSTAIN));
        sum17   = {1'b0, level_q} + {1'b0, attack_inc};
        dec17   = {1'b0, level_q} - {1'b0, decay_dec};
        rel17   = {1'b0, level_q} - {1'b0, release_dec};
        // The zero-extended level keeps the multiply signed x unsigned.
        product  = $signed(sin) * $signed({1'b0, level_q});
        sample_d = product[31:16];

        state_d = state_q;
        level_d = level_q;
        if (rise) begin
            state_d = S_ATTACK;
        end else if (fall) begin
            state_d = S_RELEASE;
        end else begin
            case (state_q)
                S_ATTACK: if (tick) begin
                    if ((attack_inc == 16'd0) || (sum17 >= 17'h0FFFF)) begin
                        level_d = 16'hFFFF;
                        state_d = S_DECAY;
                    end else begin
                        level_d = sum17[15:0];
                    end
                end
                S_DECAY: if (tick) begin
                    if ((decay_dec == 16'd0) || dec17[16] || (dec17[15:0] <= sustain_lvl)) begin
                        level_d = sustain_lvl;
                        state_d = S_SUSTAIN;
                    end else begin
                        level_d = dec17[15:0];
                    end
                end
                S_SUSTAIN: level_d = sustain_lvl;
                S_RELEASE: if (tick) begin
                    if ((release_dec == 16'd0) || rel17[16] || (rel17[15:0] == 16'd0)) begin
                        level_d = 16'd0;
                        state_d = S_IDLE;
                    end else begin
                        level_d = rel17[15:0];
                    end
                end
                S_IDLE:  level_d = 16'd0;
                default: begin
                    level_d = 16'd0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            level_q  <= 16'd0;
            cnt_q    <= '0;
            gate_q   <= 1'b0;
            sample_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            gate_q   <= gate_d;
            sample_q <= sample_d;
        end
    end

    assign sample_out = sample_q;
    assign env_level  = level_q;
    assign env_state  = state_q;
    assign active     = (state_q != S_IDLE);

endmodule

// File: tb/tb_env_adsr.sv
// Directed bench for env_adsr: a reference envelope model drives a sample
// scoreboard, and the documented level sequences are checked as constants.
module tb_env_adsr;

    localparam int PRESCALE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        gate;
    logic [15:0] sin;
    logic [15:0] attack_inc;
    logic [15:0] decay_dec;
    logic [15:0] sustain_lvl;
    logic [15:0] release_dec;
    logic [15:0] sample_out;
    logic [15:0] env_level;
    logic [2:0]  env_state;
    logic        active;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];

    int m_state  = 0;
    int m_level  = 0;
    int m_cnt    = 0;
    bit m_gate_q = 1'b0;
    bit rand_sin = 1'b0;

    env_adsr #(.PRESCALE(PRESCALE)) dut (
        .clk         (clk),
        .rst         (rst),
        .gate        (gate),
        .sin         (sin),
        .attack_inc  (attack_inc),
        .decay_dec   (decay_dec),
        .sustain_lvl (sustain_lvl),
        .release_dec (release_dec),
        .sample_out  (sample_out),
        .env_level   (env_level),
        .env_state   (env_state),
        .active      (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference envelope written from the behavioural description with plain ints.
    task automatic model_step();
        bit     tick;
        bit     rise;
        bit     fall;
        longint p;
        if (rst) begin
            exp_q.push_back(16'd0);
            m_state  = 0;
            m_level  = 0;
            m_cnt    = 0;
            m_gate_q = 1'b0;
        end else begin
            p = longint'($signed(sin)) * longint'(m_level);
            exp_q.push_back(16'(p >>> 16));
            tick = (m_cnt == PRESCALE - 1);
            rise = gate && !m_gate_q;
            fall = !gate && (m_state >= 1) && (m_state <= 3);
            if (rise) m_state = 1;
            else if (fall) m_state = 4;
            else begin
                case (m_state)
                    1: if (tick) begin
                        if (attack_inc == 0 || m_level + int'(attack_inc) >= 65535) begin
                            m_level = 65535; m_state = 2;
                        end else m_level = m_level + int'(attack_inc);
                    end
                    2: if (tick) begin
                        if (decay_dec == 0 || m_level - int'(decay_dec) <= int'(sustain_lvl)) begin
                            m_level = int'(sustain_lvl); m_state = 3;
                        end else m_level = m_level - int'(decay_dec);
                    end
                    3: m_level = int'(sustain_lvl);
                    4: if (tick) begin
                        if (release_dec == 0 || m_level - int'(release_dec) <= 0) begin
                            m_level = 0; m_state = 0;
                        end else m_level = m_level - int'(release_dec);
                    end
                    default: m_level = 0;
                endcase
            end
            m_cnt    = tick ? 0 : m_cnt + 1;
            m_gate_q = gate;
        end
    endtask

    task automatic cycle();
        logic [15:0] exp_s;
        if (rand_sin) sin = 16'($urandom_range(0, 65535));
        model_step();
        @(posedge clk);
        #1;
        exp_s = exp_q.pop_front();
        chk("sample_out", 32'(sample_out), 32'(exp_s));
        chk("env_state", 32'(env_state), 32'(m_state));
        chk("env_level", 32'(env_level), 32'(m_level));
        chk("active", 32'(active), 32'(m_state != 0));
    endtask

    task automatic wait_change(input string tag, input int budget);
        logic [15:0] prev;
        bit          done;
        prev = env_level;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            cycle();
            if (env_level !== prev) done = 1'b1;
        end
        n_assert++;
        assert (done) else begin
            n_fail++;
            $error("FAIL timeout_%s: observed no level change expected change within %0d cycles", tag, budget);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        bit done;
        done = (env_state === st);
        for (int i = 0; i < budget && !done; i++) begin
            cycle();
            if (env_state === st) done = 1'b1;
        end
        n_assert++;
        assert (done) else begin
            n_fail++;
            $error("FAIL timeout_%s: observed state %0d expected %0d", tag, env_state, st);
        end
    endtask

    logic [15:0] atk_exp[4];
    logic [15:0] rel_exp[3];

    initial begin
        atk_exp = '{16'h4000, 16'h8000, 16'hC000, 16'hFFFF};
        rel_exp = '{16'h5000, 16'h2000, 16'h0000};

        // Reset with gate already high
        rst = 1'b1; gate = 1'b1; sin = 16'h7FFF;
        attack_inc = 16'h4000; decay_dec = 16'h1000;
        sustain_lvl = 16'h8000; release_dec = 16'h3000;
        repeat (5) cycle();
        chk("rst_sample", 32'(sample_out), 32'h0);
        chk("rst_level", 32'(env_level), 32'h0);
        chk("rst_state", 32'(env_state), 32'h0);
        rst = 1'b0;
        cycle();
        chk("rst_rise_attack", 32'(env_state), 32'd1);
        rand_sin = 1'b1;

        // Attack ramp, then saturated-level multiplies
        for (int i = 0; i < 4; i++) begin
            wait_change("attack", 12);
            chk("attack_level", 32'(env_level), 32'(atk_exp[i]));
        end
        chk("attack_to_decay", 32'(env_state), 32'd2);
        rand_sin = 1'b0;
        sin = 16'h7FFF;
        cycle();
        chk("mul_max_pos", 32'(sample_out), 32'h7FFE);
        sin = 16'h8000;
        cycle();
        chk("mul_max_neg", 32'(sample_out), 32'h8000);
        rand_sin = 1'b1;

        // Decay down to sustain
        for (int i = 0; i < 7; i++) begin
            wait_change("decay", 12);
            chk("decay_level", 32'(env_level), 32'(16'hEFFF - 16'(i * 16'h1000)));
        end
        wait_change("decay_end", 12);
        chk("sustain_level", 32'(env_level), 32'h8000);
        chk("sustain_state", 32'(env_state), 32'd3);
        rand_sin = 1'b0;
        sin = 16'h4000;
        cycle();
        chk("mul_half", 32'(sample_out), 32'h2000);
        rand_sin = 1'b1;

        // Release to idle
        gate = 1'b0;
        cycle();
        chk("release_enter", 32'(env_state), 32'd4);
        chk("release_hold", 32'(env_level), 32'h8000);
        for (int i = 0; i < 3; i++) begin
            wait_change("release", 12);
            chk("release_level", 32'(env_level), 32'(rel_exp[i]));
        end
        chk("release_idle", 32'(env_state), 32'd0);
        chk("release_inactive", 32'(active), 32'd0);
        rand_sin = 1'b0;
        sin = 16'h7FFF;
        cycle();
        chk("mul_zero", 32'(sample_out), 32'h0);
        rand_sin = 1'b1;

        // Retrigger from release at 0x5000
        gate = 1'b1;
        wait_state("to_sustain", 3'd3, 200);
        gate = 1'b0;
        cycle();
        wait_change("rel_5000", 12);
        chk("retrig_pre", 32'(env_level), 32'h5000);
        gate = 1'b1;
        cycle();
        chk("retrig_state", 32'(env_state), 32'd1);
        chk("retrig_level", 32'(env_level), 32'h5000);
        wait_change("retrig_tick", 12);
        chk("retrig_next", 32'(env_level), 32'h9000);

        // Gate falls on a tick edge in attack: no level update
        repeat (PRESCALE - 1) cycle();
        gate = 1'b0;
        cycle();
        chk("fall_tick_state", 32'(env_state), 32'd4);
        chk("fall_tick_level", 32'(env_level), 32'h9000);

        // Rising edge on a tick edge in release: no level update
        repeat (PRESCALE - 1) cycle();
        gate = 1'b1;
        cycle();
        chk("rise_tick_state", 32'(env_state), 32'd1);
        chk("rise_tick_level", 32'(env_level), 32'h9000);

        // Live sustain edit
        wait_state("to_sustain2", 3'd3, 200);
        sustain_lvl = 16'h2000;
        cycle();
        chk("sustain_edit", 32'(env_level), 32'h2000);
        repeat (3) cycle();

        // Reset mid-phase
        rst = 1'b1;
        cycle();
        chk("midrst_state", 32'(env_state), 32'h0);
        chk("midrst_level", 32'(env_level), 32'h0);
        chk("midrst_sample", 32'(sample_out), 32'h0);
        rst = 1'b0;
        gate = 1'b0;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/env_adsr.md
# env_adsr

ADSR envelope stage that sits directly downstream of the sine oscillator. It takes the oscillator's 16-bit signed sample every `clk` and a note gate, and generates a 16-bit unsigned envelope level through a five-state attack/decay/sustain/release machine. It multiplies the sample by that level and outputs one registered, scaled sample per clock for the mixer/DAC stage.

## Interface
- `PRESCALE`, default 1000: envelope update period in `clk` cycles. One tick every `PRESCALE` cycles; legal values are ≥ 1.
- `clk`  in  1  system clock. Samples arrive and leave at this rate.
- `rst`  in  1  synchronous, active-high reset.
- `gate`  in  1  note held; 1 = key down.
- `sin`  in  16  signed two's-complement oscillator sample.
- `attack_inc`  in  16  level increment per tick in ATTACK.
- `decay_dec`  in  16  level decrement per tick in DECAY.
- `sustain_lvl`  in  16  unsigned sustain level.
- `release_dec`  in  16  level decrement per tick in RELEASE.
- `sample_out`  out  16  signed enveloped sample, registered.
- `env_level`  out  16  current unsigned envelope level.
- `env_state`  out  3  encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- `active`  out  1  high when `env_state != IDLE`.

## Operation
- **Reset.** On `rst`=1 at a `clk` edge, all of the following are cleared:
  - `env_state`=IDLE, `env_level`=0, `sample_out`=0;
  - prescaler counter=0;
  - `gate_q` (registered `gate`)=0.
- **Prescaler.** The counter runs 0..`PRESCALE`-1 and wraps. `tick` is asserted when the counter equals `PRESCALE`-1.
- **Gate edge detection.**
  - Rising edge = `gate`=1 and `gate_q`=0.
  - Falling condition = `gate`=0 while in ATTACK, DECAY or SUSTAIN.
  - If `gate` is held high through reset, the first cycle after reset sees a rising edge.
- **Transitions, in priority order, each evaluated per `clk`:**
  1. Rising edge, from any state → ATTACK. The level is kept, so a retrigger continues from the current level. This has no tick dependency, and no level update happens that cycle.
  2. Falling condition → RELEASE immediately. No level update that cycle.
  3. ATTACK, on tick:
     - level = min(level + `attack_inc`, 0xFFFF), computed with a 17-bit sum.
     - If the result is 0xFFFF → DECAY.
     - `attack_inc`=0: level=0xFFFF and → DECAY.
  4. DECAY, on tick:
     - If level − `decay_dec` ≤ `sustain_lvl`, or the subtraction underflows: level=`sustain_lvl` and → SUSTAIN.
     - Otherwise level −= `decay_dec`.
     - `decay_dec`=0 jumps to SUSTAIN on the first tick.
  5. SUSTAIN: level = `sustain_lvl` every clk, with no tick dependency, so live edits track.
  6. RELEASE, on tick:
     - level = max(level − `release_dec`, 0).
     - If the result is 0 → IDLE.
     - `release_dec`=0: level=0 and → IDLE.
  7. IDLE: level held at 0.
- **Multiply.** Product = signed(`sin`) × unsigned(`env_level`), a 33-bit signed value.
  - `sample_out` = product[31:16], i.e. an arithmetic shift right by 16 with floor rounding.
  - Never overflows: the result range is −32768..32766.
- Rate inputs are sampled on the tick on which they are used. Changing them mid-phase is legal.

## Timing
- `sample_out` latency is 1 cycle: `sample_out`(n+1) = f(`sin`(n), `env_level`(n)).
- `env_level` and `env_state` are registered and update on the `clk` edge that applies the transition. `active` is combinational from `env_state`.
- A gate edge takes effect on the first `clk` edge where it is seen. A tick falling in that same cycle is consumed without a level change.
- `rst` asserted mid-phase returns all outputs to their reset values on the next edge. No partial state survives.

## Test plan
All scenarios use `PRESCALE`=4.
1. **Reset.** Hold `rst`=1, `gate`=1, `sin`=0x7FFF for 5 cycles → `sample_out`=0, `env_level`=0, `env_state`=0. Release `rst` → `env_state`=1 one cycle later.
2. **Attack and decay.** `attack_inc`=0x4000, `decay_dec`=0x1000, `sustain_lvl`=0x8000, `gate` held high.
   - Attack ticks give levels 0x4000, 0x8000, 0xC000, 0xFFFF, then state=DECAY.
   - Decay ticks give levels 0xEFFF … 0x8FFF, then level 0x8000 with state=SUSTAIN.
3. **Release.** From SUSTAIN at 0x8000 with `release_dec`=0x3000, drop `gate` → state=RELEASE next cycle. Ticks give levels 0x5000, 0x2000, 0x0000, then state=IDLE and `active`=0.
4. **Multiply.** Expected one cycle later:
   - level 0xFFFF, `sin`=0x7FFF → 0x7FFE.
   - level 0xFFFF, `sin`=0x8000 → 0x8000.
   - level 0x8000, `sin`=0x4000 → 0x2000.
   - level 0, any `sin` → 0.
5. **Retrigger.** In RELEASE at level 0x5000, raise `gate` → state=ATTACK with level still 0x5000. Next tick with `attack_inc`=0x4000 → 0x9000.
6. **Simultaneous events.**
   - Rising edge on a tick cycle while in RELEASE → state=ATTACK, level unchanged.
   - `gate` falls on a tick cycle in ATTACK → state=RELEASE, level unchanged.
   - `sustain_lvl` changed 0x8000→0x2000 in SUSTAIN → level=0x2000 on the next edge.
